run_detect_scheduler: RTL
=========================

Name: run_detect_scheduler

Overview:
- Shares one serial run-length detector (input w, Moore output z, async active-high detector reset) among NREQ requesters.
- Per transaction:
  - picks a requester round-robin and captures its WIDTH-bit word;
  - clears the detector, shifts the word into it one bit per clock;
  - counts cycles with z high and reports the count with a one-cycle Done pulse.
- Sits between the requester blocks and the detector instance.

Parameters:
- NREQ, 2, number of requesters (2..8)
- WIDTH, 8, bits shifted per transaction (≥2)
- CW, $clog2(WIDTH+1), width of Count

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- Req  in  NREQ  per-requester request, level
- DataIn  in  NREQ*WIDTH  requester i word in bits [i*WIDTH +: WIDTH]
- Grant  out  NREQ  one-hot; high for the owner from CLEAR through DONE
- DetReset  out  1  detector reset; high during CLEAR and while Reset is high
- w  out  1  serial bit to detector
- z  in  1  detector Moore output
- Done  out  1  one-cycle pulse; transaction complete
- DoneId  out  $clog2(NREQ) (min 1)  index of finished requester; valid with Done
- Count  out  CW  number of z-high samples in the last transaction

Behaviour:
- Reset (synchronous):
  - state=IDLE.
  - Grant=0, Done=0, DoneId=0, Count=0, w=0.
  - Round-robin pointer set so requester 0 has top priority.
  - DetReset=1 while Reset is high.
  - A reset mid-transaction aborts it: no Done, Count cleared.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any Req is high, grant the first requester at or after pointer+1 (mod NREQ), then go to CLEAR.
  - Otherwise stay in IDLE.
  - w=0.
- CLEAR (1 cycle):
  - Grant is valid.
  - DetReset=1.
  - Granted word is captured into the shift register.
  - Count cleared; bit index cleared.
- SHIFT (WIDTH cycles):
  - Cycle j drives w = word bit WIDTH-1-j (MSB first).
  - In cycles j≥1, sample z; if high, Count+1. That z reflects bit j-1.
  - After cycle WIDTH-1, go to DRAIN.
- DRAIN (1 cycle):
  - w=0.
  - Sample z for the last bit; if high, Count+1.
- DONE (1 cycle):
  - Done=1, DoneId=owner.
  - Pointer set to the owner.
  - Grant drops on exit; go to IDLE.
- Latency:
  - Req sampled at edge E0; Done is high in cycle E0+WIDTH+3.
  - Minimum spacing between Done pulses is WIDTH+4 cycles (one IDLE cycle between transactions).
- Count:
  - At most WIDTH samples, so no overflow.
  - Holds its value from DONE until the next CLEAR.
- Req and DataIn are ignored after CLEAR. Dropping Req mid-transaction does not abort it.
- If Req is still high in the IDLE after DONE, that requester competes again at lowest priority.
- Simultaneous requests: round-robin only; no starvation.
- DetReset is driven as a registered state decode ORed with Reset, so it is glitch-free.

Optional Feature:
- Macro RUNSCHED_LSB_FIRST_EN.
- Defined: SHIFT cycle j drives w = word bit j (LSB first).
- Undefined: MSB first, as above.
- Count semantics and timing are unchanged either way.

Test Plan:
- Reset, then Req=2'b01, DataIn[7:0]=8'h00:
  - Grant=01 in the next cycle; DetReset high exactly 1 cycle.
  - Done 11 cycles after the sampling edge.
  - Count=5, DoneId=0.
- Req=2'b10, DataIn[15:8]=8'h0F: w sequence 0,0,0,0,1,1,1,1 (MSB first); Count=2, DoneId=1.
- DataIn=8'h55: Count=0.
- DataIn=8'h07: Count=2.
- Req=2'b11 held for 3 transactions: Grant order 01,10,01; each pair of Done pulses 12 cycles apart.
- Reset asserted during SHIFT cycle 3:
  - Next cycle IDLE, Grant=0, Count=0, no Done, DetReset=1.
  - After release, Req=01 gives a normal transaction.
- With RUNSCHED_LSB_FIRST_EN defined, DataIn=8'h0F: w sequence 1,1,1,1,0,0,0,0; Count=2.

Source files
------------

// File: rtl/run_detect_scheduler.sv
// run_detect_scheduler: shares one serial run-length detector among NREQ
// requesters. Each transaction grants one requester round-robin, clears the
// detector, shifts the granted word into it one bit per clock and reports the
// number of cycles the detector output z was high.
// Optional build macro: RUNSCHED_LSB_FIRST_EN (shift LSB first instead of MSB).
module run_detect_scheduler #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1),
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int IXW  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [NREQ-1:0]         Req,
  input  logic [NREQ*WIDTH-1:0]   DataIn,
  output logic [NREQ-1:0]         Grant,
  output logic                    DetReset,
  output logic                    w,
  input  logic                    z,
  output logic                    Done,
  output logic [IDW-1:0]          DoneId,
  output logic [CW-1:0]           Count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NREQ-1:0]    r_grant;
  logic [IDW-1:0]     r_owner;
  logic [IDW-1:0]     r_ptr;
  logic               r_done;
  logic [IDW-1:0]     r_doneid;
  logic               r_detrst;
  logic [CW-1:0]      r_count;
  logic [WIDTH-1:0]   r_shreg;
  logic [IXW-1:0]     r_idx;
  logic               w_any;
  logic [IDW-1:0]     w_pick;

  // Round-robin pick: scan from the farthest offset down so the requester
  // nearest to pointer+1 is the one left standing.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (Req[(int'(r_ptr) + k) % NREQ]) begin
        w_any  = 1'b1;
        w_pick = IDW'((int'(r_ptr) + k) % NREQ);
      end
    end
  end

  // Next-state decode for the transaction sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_CLEAR;
      S_CLEAR: w_next = S_SHIFT;
      S_SHIFT: if (r_idx == IXW'(WIDTH - 1)) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Control registers: grant/owner, pointer, z-high counter, Done and the
  // registered detector-clear decode.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_grant  <= '0;
      r_owner  <= '0;
      r_ptr    <= IDW'(NREQ - 1);
      r_done   <= 1'b0;
      r_doneid <= '0;
      r_detrst <= 1'b0;
      r_count  <= '0;
    end else begin
      r_done   <= (w_next == S_DONE);
      r_detrst <= (w_next == S_CLEAR);
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_pick;
            r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          end
        end
        S_CLEAR: r_count <= '0;
        S_SHIFT: begin
          // z in shift cycle 0 still reflects the cleared detector.
          if ((r_idx != '0) && z) r_count <= r_count + CW'(1);
        end
        S_DRAIN: begin
          if (z) r_count <= r_count + CW'(1);
          r_doneid <= r_owner;
        end
        S_DONE: begin
          r_ptr   <= r_owner;
          r_grant <= '0;
        end
        default: ;
      endcase
    end
  end

  // Datapath: capture the granted word and shift it out one bit per cycle.
  always_ff @(posedge Clock) begin
    if (r_state == S_CLEAR) begin
      r_shreg <= DataIn[int'(r_owner)*WIDTH +: WIDTH];
      r_idx   <= '0;
    end else if (r_state == S_SHIFT) begin
`ifdef RUNSCHED_LSB_FIRST_EN
      r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
`else
      r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
`endif
      r_idx   <= r_idx + IXW'(1);
    end
  end

`ifdef RUNSCHED_LSB_FIRST_EN
  assign w = (r_state == S_SHIFT) ? r_shreg[0] : 1'b0;
`else
  assign w = (r_state == S_SHIFT) ? r_shreg[WIDTH-1] : 1'b0;
`endif

  assign DetReset = r_detrst | Reset;
  assign Grant    = r_grant;
  assign Done     = r_done;
  assign DoneId   = r_doneid;
  assign Count    = r_count;

endmodule
